// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared states, BCD constants and digit check for the serial BCD adder
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    CHK  = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] BCD_CORR = 4'b0110;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// rtl/bcd_serial_add_ctrl_if.sv - operand/result handshake bundle of the serial BCD adder
interface bcd_serial_add_ctrl_if #(
  parameter int NDIG = 2
);

  logic                start;
  logic [4*NDIG-1:0]   a;
  logic [4*NDIG-1:0]   b;
  logic                cin;
  logic                ready;
  logic [4*NDIG-1:0]   sum;
  logic                cout;
  logic                done;
  logic                err;

  modport master (
    output start, a, b, cin,
    input  ready, sum, cout, done, err
  );

  modport slave (
    input  start, a, b, cin,
    output ready, sum, cout, done, err
  );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - bit-serial packed BCD adder sequencing a single full_adder cell
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int         W    = 4 * NDIG;
  localparam logic [2:0] LAST = 3'(NDIG - 1);

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic           carry;
  logic           dcarry;
  logic [3:0]     dig;
  logic [1:0]     bitc;
  logic [2:0]     digit;
  logic [W-1:0]   sum_r;
  logic           cout_r;
  logic           done_r;
  logic           err_r;
  logic           ready_r;

  logic           fa_a;
  logic           fa_b;
  logic           fa_s;
  logic           fa_cout;
  logic [3:0]     dig_next;
  logic           inputs_bad;
  logic           commit_en;
  logic [3:0]     commit_val;
  logic           commit_dc;

  // The one adder cell serves both the binary digit add and the +6 correction pass.
  always_comb begin
    fa_a = a_sh[0];
    fa_b = b_sh[0];
    if (state == CORR) begin
      fa_a = dig[bitc];
      fa_b = BCD_CORR[bitc];
    end
  end

  full_adder u_fa (
    .s    (fa_s),
    .cout (fa_cout),
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry)
  );

  always_comb begin
    dig_next       = dig;
    dig_next[bitc] = fa_s;
  end

  always_comb begin
    inputs_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_digit_valid(bus.a[4*i +: 4]) || !bcd_digit_valid(bus.b[4*i +: 4]))
        inputs_bad = 1'b1;
    end
  end

  // A digit is committed either straight from CHK or after its last correction bit.
  always_comb begin
    commit_en  = 1'b0;
    commit_val = dig;
    commit_dc  = 1'b0;
    if (state == CHK && {carry, dig} <= 5'd9) begin
      commit_en = 1'b1;
    end else if (state == CORR && bitc == 2'd3) begin
      commit_en  = 1'b1;
      commit_val = dig_next;
      commit_dc  = dcarry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      dcarry  <= 1'b0;
      dig     <= '0;
      bitc    <= '0;
      digit   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry   <= bus.cin;
            dcarry  <= 1'b0;
            dig     <= '0;
            bitc    <= '0;
            digit   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ready_r <= 1'b0;
            if (inputs_bad) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              err_r  <= 1'b0;
              state  <= ADD;
            end
          end
        end
        ADD: begin
          dig   <= dig_next;
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bitc  <= bitc + 2'd1;
          if (bitc == 2'd3)
            state <= CHK;
        end
        CHK: begin
          if ({carry, dig} > 5'd9) begin
            dcarry <= 1'b1;
            carry  <= 1'b0;
            bitc   <= '0;
            state  <= CORR;
          end
        end
        CORR: begin
          dig   <= dig_next;
          carry <= fa_cout;
          bitc  <= bitc + 2'd1;
        end
        DONE: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (commit_en) begin
        for (int i = 0; i < NDIG; i++) begin
          if (digit == 3'(i))
            sum_r[4*i +: 4] <= commit_val;
        end
        carry <= commit_dc;
        bitc  <= '0;
        if (digit == LAST) begin
          cout_r <= commit_dc;
          done_r <= 1'b1;
          state  <= DONE;
        end else begin
          digit <= digit + 3'd1;
          state <= ADD;
        end
      end
    end
  end

  assign bus.ready = ready_r;
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - bench for bcd_serial_add_ctrl against a decimal-arithmetic model
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  logic         lit_en = 1'b0;
  logic [W-1:0] lit_sum = '0;
  logic         lit_cout = 1'b0;
  logic         lit_err = 1'b0;
  int           lit_lat = 0;

  logic         mready = 1'b1;
  logic         mbusy  = 1'b0;
  logic         mdone  = 1'b0;
  logic [W-1:0] msum   = '0;
  logic         mcout  = 1'b0;
  logic         merr   = 1'b0;
  int           mn     = 0;
  int           mlat   = 0;
  logic [W-1:0] fsum   = '0;
  logic         fcout  = 1'b0;

  // Decimal reference: digit-wise add with carry, count carrying digits for latency.
  function automatic void bcd_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic e,
                                  output int lat);
    int cy;
    int k;
    int raw;
    s  = '0;
    co = 1'b0;
    e  = 1'b0;
    k  = 0;
    cy = c ? 1 : 0;
    for (int i = 0; i < NDIG; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) e = 1'b1;
    if (e) begin
      lat = 1;
      return;
    end
    for (int i = 0; i < NDIG; i++) begin
      raw = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cy;
      s[4*i +: 4] = 4'(raw % 10);
      cy = raw / 10;
      k += cy;
    end
    co  = (cy != 0);
    lat = 5 * NDIG + 4 * k + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mready = 1'b1; mbusy = 1'b0; mdone = 1'b0;
      msum = '0; mcout = 1'b0; merr = 1'b0; mn = 0;
    end else begin
      mdone = 1'b0;
      if (mready && bus.start) begin
        bcd_ref(bus.a, bus.b, bus.cin, fsum, fcout, merr, mlat);
        mready = 1'b0; mbusy = 1'b1; mn = 0;
        msum = '0; mcout = 1'b0;
      end else if (mbusy) begin
        mn++;
        if (mn == mlat) begin
          mbusy  = 1'b0;
          mready = 1'b1;
        end
      end
      if (mbusy && mn == mlat - 1) begin
        mdone = 1'b1;
        msum  = fsum;
        mcout = fcout;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", 32'(bus.ready), 32'(mready));
      check("done",  32'(bus.done),  32'(mdone));
      check("err",   32'(bus.err),   32'(merr));
      check("cout",  32'(bus.cout),  32'(mcout));
      if (!mbusy || mdone)
        check("sum", 32'(bus.sum), 32'(msum));
      if (mdone && lit_en) begin
        check("lit_sum",  32'(bus.sum),  32'(lit_sum));
        check("lit_cout", 32'(bus.cout), 32'(lit_cout));
        check("lit_err",  32'(bus.err),  32'(lit_err));
        check("lit_lat",  32'(mn + 1),   32'(lit_lat));
      end
    end
  end

  task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                    input logic le, input logic [W-1:0] ls, input logic lc,
                    input logic lerr, input int ll);
    @(posedge clk); #1;
    bus.a = ta; bus.b = tb2; bus.cin = tc; bus.start = 1'b1;
    lit_en = le; lit_sum = ls; lit_cout = lc; lit_err = lerr; lit_lat = ll;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit pulses);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.done) bus.start = 1'b0;
      else if (pulses && $urandom_range(0, 4) == 0) begin
        bus.start = 1'b1;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end else bus.start = 1'b0;
    end while (!bus.done && n < 400);
    if (!bus.done) begin
      $display("FAIL wait_done: no done within %0d cycles", n);
      $fatal(1);
    end
  endtask

  function automatic logic [W-1:0] rnd_op(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 5) == 0)
      v[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    go(8'h45, 8'h32, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 11);
    wait_done(1'b0);
    go(8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 19);
    wait_done(1'b0);
    go(8'h58, 8'h27, 1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 15);
    wait_done(1'b0);
    go(8'h3A, 8'h10, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1);
    wait_done(1'b0);
    go(8'h45, 8'h32, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 11);
    wait_done(1'b0);

    // Stray starts mid-operation and in the DONE cycle; the DONE-cycle start is held into IDLE.
    go(8'h45, 8'h32, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 11);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h99; bus.b = 8'h99;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'h45; bus.b = 8'h32;
    wait_done(1'b0);
    bus.start = 1'b1; bus.a = 8'h58; bus.b = 8'h27; bus.cin = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bus.start = 1'b0;
    lit_en = 1'b1; lit_sum = 8'h86; lit_cout = 1'b0; lit_err = 1'b0; lit_lat = 15;
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b0);

    go(8'h99, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    go(8'h45, 8'h32, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 11);
    wait_done(1'b0);

    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      go(rnd_op(1'b1), rnd_op(1'b1), 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b0, 0);
      wait_done(1'b1);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
